regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Write-port scheduler and scoreboard for the integer register file. Arbitrates the register file's single write port between the in-order pipeline writeback (requester A) and the long-latency unit return path (requester B, e.g. load/multiply/divide completion). Tracks registers with outstanding long-latency writes and stalls decode on RAW/WAW hazards against them. Sits between memory/writeback stages and the register file write inputs.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count (index width 5)
- MAX_WAIT, 4, cycles B may be refused before it is forced to win (≥1)

- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- iss_valid_i  in  1  decode presents an instruction
- iss_long_i  in  1  instruction writes rd via requester B later
- iss_rd_i  in  5  destination of issuing instruction
- D_rs1_i, D_rs2_i  in  5  decode source indices
- iss_stall_o  out  1  hazard stall to decode (combinational)
- a_valid_i / a_ready_o  in / out  1  pipeline writeback handshake
- a_rd_i, a_data_i  in  5, XLEN  pipeline write index/data
- b_valid_i / b_ready_o  in / out  1  long-unit writeback handshake
- b_rd_i, b_data_i  in  5, XLEN  long-unit write index/data
- wb_we_o, wb_rd_o, wb_data_o  out  1, 5, XLEN  registered write to register file
- sb_busy_o  out  NREG  pending-write vector (bit 0 always 0)

## Operation
- Handshake: transfer when valid & ready; requester holds valid, rd, data stable until transfer.
- Arbitration: force_b = b_valid_i & (wait_cnt ≥ MAX_WAIT). a_ready_o = !force_b. b_ready_o = force_b | !a_valid_i. At most one transfer per cycle.
- wait_cnt: +1 (saturating at MAX_WAIT) each cycle b_valid_i & !b_ready_o; cleared on B transfer or when b_valid_i low.
- Write register: on a transfer, next cycle wb_we_o = (rd ≠ 0), wb_rd_o/wb_data_o = winner's; else wb_we_o = 0, rd/data hold. Writes to x0 are accepted and dropped.
- Scoreboard busy[NREG]: set busy[iss_rd_i] at edge where iss_valid_i & iss_long_i & !iss_stall_o & iss_rd_i ≠ 0. Clear busy[r] at the edge where wb_we_o is high for a B-sourced write to r (registered flag wb_from_b), i.e. the same edge the register file captures the data.
- iss_stall_o = iss_valid_i & (busy[D_rs1_i] | busy[D_rs2_i] | busy[iss_rd_i]). Index 0 never busy.
- Set and clear of the same register on one edge cannot occur (WAW stall); if both occur, set wins.
- A writes to a busy register are legal (no scoreboard effect).

## Timing
- Reset (async assert, sync release): wb_we_o=0, wb_rd_o=0, wb_data_o=0, busy=0, wait_cnt=0, wb_from_b=0; a_ready_o=1, b_ready_o=1 when inputs idle.
- Transfer at cycle t → wb_we_o at t+1 → register file updated at end of t+1 → readable t+2.
- busy[r] drops from t+2 after B transfer at t; decode stalled on r through t+1, reads correct data at t+2.
- Long issue at edge ending cycle t → dependents stall from t+1.
- Reset mid-operation discards all pending tags; long unit must be flushed by the same reset.
- Worst-case B latency with continuous A traffic: MAX_WAIT+1 cycles from b_valid_i.

## Structure
- Shared package: XLEN, NREG, register-index width, x0 constant.
- One sub-module natural: regfile_scoreboard (busy vector, set/clear, three-port hazard lookup). Arbiter, wait counter and write register stay in top.

## Test plan
- Reset mid-traffic: rst_n low with busy=0x0000_0020, wb_we_o=1 → all outputs 0 immediately, busy=0 after release.
- A only: a_rd=5, a_data=0xDEAD_BEEF one cycle → wb_we_o=1, wb_rd_o=5, wb_data_o=0xDEAD_BEEF next cycle, then we=0.
- Starvation: a_valid held high 10 cycles, b_valid rises cycle 0 (b_rd=7) with MAX_WAIT=4 → b_ready_o at cycle 4, a_ready_o=0 that cycle, wb_rd_o=7 at cycle 5.
- RAW scoreboard: long issue rd=3, next instruction rs1=3 → iss_stall_o=1 until two cycles after B transfer to x3, then 0.
- WAW: busy[9]=1, issue long rd=9 → stalled, busy unchanged; after B clears x9 issue succeeds and busy[9]=1 again.
- x0: long issue rd=0 → busy stays 0, no stall; A write rd=0 → accepted, wb_we_o=0.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// regfile_wb_sched_pkg
// Shared definitions for the register-file write-port scheduler:
// data width, architectural register count, index width, the x0 index
// and a one-hot helper used by the scoreboard.
package regfile_wb_sched_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xdata_t;
  typedef logic [NREG-1:0]      reg_mask_t;

  localparam reg_idx_t REG_X0 = '0;

  // One-hot mask selecting a single architectural register.
  function automatic reg_mask_t reg_onehot(input reg_idx_t idx);
    reg_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if
// Bundles the two register-file write requesters:
//   A : in-order pipeline writeback  (a_valid, a_rd, a_data / a_ready)
//   B : long-latency unit completion (b_valid, b_rd, b_data / b_ready)
// master modport = requester side, slave modport = scheduler side.
interface regfile_wb_sched_if;
  import regfile_wb_sched_pkg::*;

  logic     a_valid;
  logic     a_ready;
  reg_idx_t a_rd;
  xdata_t   a_data;

  logic     b_valid;
  logic     b_ready;
  reg_idx_t b_rd;
  xdata_t   b_data;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/regfile_wb_sched_scoreboard.sv
// regfile_scoreboard
// Pending-write tracker for registers awaiting a long-latency result.
// Ports:
//   clk_i, rst_n        clock / async active-low reset
//   set_en_i, set_idx_i mark a register busy (long instruction issued)
//   clr_en_i, clr_idx_i release a register (B result written)
//   rs1_i, rs2_i, rd_i  decode indices looked up for hazards
//   hazard_o            any looked-up register is busy
//   busy_o              full busy vector, bit 0 held at 0
module regfile_scoreboard
  import regfile_wb_sched_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_n,
  input  logic      set_en_i,
  input  reg_idx_t  set_idx_i,
  input  logic      clr_en_i,
  input  reg_idx_t  clr_idx_i,
  input  reg_idx_t  rs1_i,
  input  reg_idx_t  rs2_i,
  input  reg_idx_t  rd_i,
  output logic      hazard_o,
  output reg_mask_t busy_o
);

  reg_mask_t busy_q, busy_d;

  // Clear is applied before set so that a coincident set wins; x0 is
  // forced idle so lookups on index 0 never report a hazard.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d = busy_d & ~reg_onehot(clr_idx_i);
    end
    if (set_en_i) begin
      busy_d = busy_d | reg_onehot(set_idx_i);
    end
    busy_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // rd is included so a second long write to a pending register (WAW)
  // is held back until the first result has landed.
  assign hazard_o = busy_q[rs1_i] | busy_q[rs2_i] | busy_q[rd_i];
  assign busy_o   = busy_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Write-port scheduler for the integer register file. Arbitrates the
// single write port between pipeline writeback (A, normally preferred)
// and the long-latency return path (B, forced to win after MAX_WAIT
// refused cycles), registers the winning write, and stalls decode on
// hazards against registers with outstanding long-latency writes.
// Ports:
//   clk_i, rst_n                  clock / async active-low reset
//   iss_valid_i, iss_long_i       decode presents an instruction / it is long
//   iss_rd_i, D_rs1_i, D_rs2_i    decode destination and source indices
//   iss_stall_o                   combinational hazard stall to decode
//   wb                            A/B write requesters (slave side)
//   wb_we_o, wb_rd_o, wb_data_o   registered register-file write
//   sb_busy_o                     pending-write vector
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     iss_valid_i,
  input  logic                     iss_long_i,
  input  reg_idx_t                 iss_rd_i,
  input  reg_idx_t                 D_rs1_i,
  input  reg_idx_t                 D_rs2_i,
  output logic                     iss_stall_o,
  regfile_wb_sched_if.slave        wb,
  output logic                     wb_we_o,
  output reg_idx_t                 wb_rd_o,
  output xdata_t                   wb_data_o,
  output reg_mask_t                sb_busy_o
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           force_b;
  logic           a_fire, b_fire;

  logic     wb_we_q, wb_we_d;
  reg_idx_t wb_rd_q, wb_rd_d;
  xdata_t   wb_data_q, wb_data_d;
  logic     wb_from_b_q, wb_from_b_d;

  logic sb_hazard;
  logic sb_set_en;
  logic sb_clr_en;

  // A has priority until B has been refused MAX_WAIT times; then A is
  // blocked for one cycle. The two readies are never both usable at once
  // (b_ready needs !a_valid or force_b, and force_b drops a_ready).
  assign force_b    = wb.b_valid & (wait_cnt_q >= WAIT_LIMIT);
  assign wb.a_ready = ~force_b;
  assign wb.b_ready = force_b | ~wb.a_valid;
  assign a_fire     = wb.a_valid & wb.a_ready;
  assign b_fire     = wb.b_valid & wb.b_ready;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!wb.b_valid || b_fire) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WAIT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Writes to x0 are accepted but produce no register-file write enable.
  // wb_from_b marks the write that releases a scoreboard entry.
  always_comb begin
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_from_b_d = 1'b0;
    if (b_fire) begin
      wb_we_d     = (wb.b_rd != REG_X0);
      wb_rd_d     = wb.b_rd;
      wb_data_d   = wb.b_data;
      wb_from_b_d = 1'b1;
    end else if (a_fire) begin
      wb_we_d     = (wb.a_rd != REG_X0);
      wb_rd_d     = wb.a_rd;
      wb_data_d   = wb.a_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_from_b_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_from_b_q <= wb_from_b_d;
    end
  end

  // The busy bit is released on the same edge the register file captures
  // the B result, so dependents read the new value on the following cycle.
  assign iss_stall_o = iss_valid_i & sb_hazard;
  assign sb_set_en   = iss_valid_i & iss_long_i & ~iss_stall_o & (iss_rd_i != REG_X0);
  assign sb_clr_en   = wb_we_q & wb_from_b_q;

  regfile_scoreboard u_scoreboard (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .set_en_i  (sb_set_en),
    .set_idx_i (iss_rd_i),
    .clr_en_i  (sb_clr_en),
    .clr_idx_i (wb_rd_q),
    .rs1_i     (D_rs1_i),
    .rs2_i     (D_rs2_i),
    .rd_i      (iss_rd_i),
    .hazard_o  (sb_hazard),
    .busy_o    (sb_busy_o)
  );

  assign wb_we_o   = wb_we_q;
  assign wb_rd_o   = wb_rd_q;
  assign wb_data_o = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched
// Directed scenarios for the write-port scheduler. Every write the bench
// expects to reach the register file is queued when its transfer is
// issued; a monitor pops and compares on each cycle wb_we_o is high.
// Handshake readiness, stall and busy vector are checked inline.
module tb_regfile_wb_sched;
  import regfile_wb_sched_pkg::*;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wbExp_t;

  logic        clk_i;
  logic        rst_n;
  logic        iss_valid_i;
  logic        iss_long_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  D_rs1_i;
  logic [4:0]  D_rs2_i;
  logic        iss_stall_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic [31:0] sb_busy_o;

  int compared;
  int mismatched;
  wbExp_t expQ[$];

  regfile_wb_sched_if wbIf ();

  regfile_wb_sched #(.MAX_WAIT(4)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .iss_valid_i (iss_valid_i),
    .iss_long_i  (iss_long_i),
    .iss_rd_i    (iss_rd_i),
    .D_rs1_i     (D_rs1_i),
    .D_rs2_i     (D_rs2_i),
    .iss_stall_o (iss_stall_o),
    .wb          (wbIf.slave),
    .wb_we_o     (wb_we_o),
    .wb_rd_o     (wb_rd_o),
    .wb_data_o   (wb_data_o),
    .sb_busy_o   (sb_busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aData,
                               input logic bV, input logic [4:0] bRd, input logic [31:0] bData,
                               input logic issV, input logic issLong, input logic [4:0] issRd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    wbIf.a_valid = aV;
    wbIf.a_rd    = aRd;
    wbIf.a_data  = aData;
    wbIf.b_valid = bV;
    wbIf.b_rd    = bRd;
    wbIf.b_data  = bData;
    iss_valid_i  = issV;
    iss_long_i   = issLong;
    iss_rd_i     = issRd;
    D_rs1_i      = rs1;
    D_rs2_i      = rs2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pushExp(input logic [4:0] rd, input logic [31:0] data);
    wbExp_t e;
    e.rd   = rd;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Monitor: every register-file write must match the oldest expected one.
  initial begin
    wbExp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n && wb_we_o) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL wb_unexpected: got rd=%0d data=0x%0h, expected no write",
                   wb_rd_o, wb_data_o);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_write", {27'd0, wb_rd_o, wb_data_o}, {27'd0, e.rd, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset state with idle inputs
    #3;
    checkOutput("rst_we", {63'd0, wb_we_o}, 64'd0);
    checkOutput("rst_rd", {59'd0, wb_rd_o}, 64'd0);
    checkOutput("rst_data", {32'd0, wb_data_o}, 64'd0);
    checkOutput("rst_busy", {32'd0, sb_busy_o}, 64'd0);
    checkOutput("rst_a_ready", {63'd0, wbIf.a_ready}, 64'd1);
    checkOutput("rst_b_ready", {63'd0, wbIf.b_ready}, 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // A only: one write to x5
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk_i);
    checkOutput("a_only_ready", {63'd0, wbIf.a_ready}, 64'd1);
    pushExp(5'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    @(negedge clk_i);
    checkOutput("a_only_we", {63'd0, wb_we_o}, 64'd1);
    checkOutput("a_only_rd", {59'd0, wb_rd_o}, 64'd5);
    tick();
    @(negedge clk_i);
    checkOutput("a_only_we_drop", {63'd0, wb_we_o}, 64'd0);
    tick();

    // Starvation: A busy for 10 cycles, B waits and is forced in at cycle 4
    for (int cyc = 0; cyc < 10; cyc++) begin
      logic [4:0]  aRd;
      logic [31:0] aData;
      logic        bV;
      aRd   = 5'(10 + cyc);
      aData = 32'h1000 + 32'(cyc);
      bV    = (cyc <= 4);
      applyStimulus(1'b1, aRd, aData, bV, 5'd7, 32'h0000_0077, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      @(negedge clk_i);
      checkOutput($sformatf("starve_a_ready_c%0d", cyc), {63'd0, wbIf.a_ready},
                  (cyc != 4) ? 64'd1 : 64'd0);
      if (cyc <= 4) begin
        checkOutput($sformatf("starve_b_ready_c%0d", cyc), {63'd0, wbIf.b_ready},
                    (cyc == 4) ? 64'd1 : 64'd0);
      end
      if (cyc == 4) pushExp(5'd7, 32'h0000_0077);
      else          pushExp(aRd, aData);
      if (cyc == 5) checkOutput("starve_b_wb_rd", {59'd0, wb_rd_o}, 64'd7);
      tick();
    end
    idle();
    tick();
    tick();

    // RAW: long issue to x3, dependent on rs1=x3 stalls until B lands
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
    @(negedge clk_i);
    checkOutput("raw_issue_stall", {63'd0, iss_stall_o}, 64'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd4, 5'd3, 5'd0);
    @(negedge clk_i);
    checkOutput("raw_stall_0", {63'd0, iss_stall_o}, 64'd1);
    checkOutput("raw_busy", {32'd0, sb_busy_o}, 64'h0000_0008);
    tick();
    @(negedge clk_i);
    checkOutput("raw_stall_1", {63'd0, iss_stall_o}, 64'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0000_0333, 1'b1, 1'b0, 5'd4, 5'd3, 5'd0);
    @(negedge clk_i);
    checkOutput("raw_b_ready", {63'd0, wbIf.b_ready}, 64'd1);
    checkOutput("raw_stall_t", {63'd0, iss_stall_o}, 64'd1);
    pushExp(5'd3, 32'h0000_0333);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd4, 5'd3, 5'd0);
    @(negedge clk_i);
    checkOutput("raw_stall_t1", {63'd0, iss_stall_o}, 64'd1);
    tick();
    @(negedge clk_i);
    checkOutput("raw_stall_t2", {63'd0, iss_stall_o}, 64'd0);
    checkOutput("raw_busy_clr", {32'd0, sb_busy_o}, 64'd0);
    tick();
    idle();

    // WAW: second long write to busy x9 is held until x9 is released
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd9, 5'd1, 5'd2);
    @(negedge clk_i);
    checkOutput("waw_busy", {32'd0, sb_busy_o}, 64'h0000_0200);
    checkOutput("waw_stall", {63'd0, iss_stall_o}, 64'd1);
    tick();
    @(negedge clk_i);
    checkOutput("waw_busy_hold", {32'd0, sb_busy_o}, 64'h0000_0200);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0999, 1'b1, 1'b1, 5'd9, 5'd1, 5'd2);
    pushExp(5'd9, 32'h0000_0999);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd9, 5'd1, 5'd2);
    @(negedge clk_i);
    checkOutput("waw_stall_t1", {63'd0, iss_stall_o}, 64'd1);
    tick();
    @(negedge clk_i);
    checkOutput("waw_stall_t2", {63'd0, iss_stall_o}, 64'd0);
    checkOutput("waw_busy_clr", {32'd0, sb_busy_o}, 64'd0);
    tick();
    idle();
    @(negedge clk_i);
    checkOutput("waw_busy_reset", {32'd0, sb_busy_o}, 64'h0000_0200);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_9999, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pushExp(5'd9, 32'h0000_9999);
    tick();
    idle();
    tick();
    @(negedge clk_i);
    checkOutput("waw_busy_final", {32'd0, sb_busy_o}, 64'd0);
    tick();

    // x0: long issue to x0 sets nothing; A write to x0 accepted, no enable
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    @(negedge clk_i);
    checkOutput("x0_issue_stall", {63'd0, iss_stall_o}, 64'd0);
    tick();
    applyStimulus(1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk_i);
    checkOutput("x0_busy", {32'd0, sb_busy_o}, 64'd0);
    checkOutput("x0_a_ready", {63'd0, wbIf.a_ready}, 64'd1);
    tick();
    idle();
    @(negedge clk_i);
    checkOutput("x0_we", {63'd0, wb_we_o}, 64'd0);
    tick();

    // Reset mid-traffic: busy=x5 and a write in flight
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd6, 32'h0000_0066, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk_i);
    checkOutput("mid_busy", {32'd0, sb_busy_o}, 64'h0000_0020);
    tick();
    idle();
    checkOutput("mid_we_before", {63'd0, wb_we_o}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_we", {63'd0, wb_we_o}, 64'd0);
    checkOutput("mid_rst_rd", {59'd0, wb_rd_o}, 64'd0);
    checkOutput("mid_rst_data", {32'd0, wb_data_o}, 64'd0);
    checkOutput("mid_rst_busy", {32'd0, sb_busy_o}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk_i);
    checkOutput("post_rst_busy", {32'd0, sb_busy_o}, 64'd0);
    checkOutput("post_rst_we", {63'd0, wb_we_o}, 64'd0);
    checkOutput("post_rst_a_ready", {63'd0, wbIf.a_ready}, 64'd1);
    checkOutput("post_rst_b_ready", {63'd0, wbIf.b_ready}, 64'd1);
    tick();
    tick();

    checkOutput("exp_queue_drained", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
